// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame geometry, retry limit, timing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // data[7:0] + parity + stop; the start bit is driven during REQ
    localparam int PS2_FRAME_BITS  = 10;
    localparam int PS2_MAX_RETRIES = 2;

    // Convert a microsecond interval into system clock cycles (64-bit intermediate avoids overflow)
    function automatic int us_to_cycles(input longint clk_hz, input longint us);
        longint cyc;
        cyc = (clk_hz * us) / longint'(1000000);
        return int'(cyc);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizer for the PS/2 clock and data pins with registered falling-edge strobes.
// Latency: synced level 2 cycles after the pin, fall strobe 3 cycles after the pin edge.
// Backpressure: none; free-running sampler.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_pin_i,
    input  logic data_pin_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o,
    output logic data_fall_o
);

    logic [1:0] clk_meta_q;
    logic [1:0] data_meta_q;
    logic       clk_prev_q;
    logic       data_prev_q;
    logic       clk_fall_q;
    logic       data_fall_q;

    // Synchronize both pins (idle-high bus) and register 1->0 transitions of the synced levels
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            data_prev_q <= 1'b1;
            clk_fall_q  <= 1'b0;
            data_fall_q <= 1'b0;
        end else begin
            clk_meta_q  <= {clk_meta_q[0], clk_pin_i};
            data_meta_q <= {data_meta_q[0], data_pin_i};
            clk_prev_q  <= clk_meta_q[1];
            data_prev_q <= data_meta_q[1];
            clk_fall_q  <= clk_prev_q & ~clk_meta_q[1];
            data_fall_q <= data_prev_q & ~data_meta_q[1];
        end
    end

    assign clk_sync_o  = clk_meta_q[1];
    assign data_sync_o = data_meta_q[1];
    assign clk_fall_o  = clk_fall_q;
    assign data_fall_o = data_fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, 10 bits out, ACK, line idle).
// Latency: ~C_INHIBIT_US plus 11 device clocks per frame; done pulses one cycle at frame end.
// Backpressure: tx_ready low whenever busy; tx_valid while busy is ignored. Retries under PS2_HOST_TX_RETRY_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int C_CLK_HZ           = 25000000,
    parameter int C_INHIBIT_US       = 100,
    parameter int C_START_TIMEOUT_US = 15000,
    parameter int C_BIT_TIMEOUT_US   = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int INH_CYC   = us_to_cycles(C_CLK_HZ, C_INHIBIT_US);
    localparam int START_CYC = us_to_cycles(C_CLK_HZ, C_START_TIMEOUT_US);
    localparam int BIT_CYC   = us_to_cycles(C_CLK_HZ, C_BIT_TIMEOUT_US);
    localparam int WD_MAX    = (START_CYC > BIT_CYC) ? START_CYC : BIT_CYC;
    localparam int WD_W      = $clog2(WD_MAX) + 1;
    localparam int INH_W     = $clog2(INH_CYC) + 1;

    // Counters run down to zero, so loads are one less than the interval length
    localparam logic [INH_W-1:0] INH_LOAD   = INH_W'(INH_CYC - 1);
    localparam logic [WD_W-1:0]  START_LOAD = WD_W'(START_CYC - 1);
    localparam logic [WD_W-1:0]  BIT_LOAD   = WD_W'(BIT_CYC - 1);

    ps2_state_e       state_q;
    logic [7:0]       byte_q;
    logic             parity_q;
    logic [9:0]       frame_q;
    logic [3:0]       bitcnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic             ack_q;
    logic             tx_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             ack_ok_q;
    logic             err_timeout_q;
    logic             clk_oe_q;
    logic             data_oe_q;

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic data_fall_unused;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .clk_pin_i   (ps2_clk_i),
        .data_pin_i  (ps2_data_i),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall),
        .data_fall_o (data_fall_unused)
    );

    logic wd_active;
    logic finish_ev;
    logic timeout_ev;
    logic attempt_end;
    logic attempt_ok;
    logic retry_left;

    // Line-idle completion wins over a simultaneous expiry, and a fall in the expiry cycle counts as a fall
    assign wd_active   = state_q inside {REQ, SHIFT, ACK, WAIT_IDLE};
    assign finish_ev   = (state_q == WAIT_IDLE) && clk_sync && data_sync;
    assign timeout_ev  = wd_active && (wd_q == '0) && !clk_fall && !finish_ev;
    assign attempt_end = finish_ev || timeout_ev;
    assign attempt_ok  = finish_ev && ack_q;

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0] retry_q;

    assign retry_left = (retry_q < 2'(PS2_MAX_RETRIES));

    // Count failed attempts of the current byte; cleared when a new byte is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= 2'd0;
        end else if (state_q == IDLE && tx_valid && tx_ready_q) begin
            retry_q <= 2'd0;
        end else if (attempt_end && !attempt_ok && retry_left) begin
            retry_q <= retry_q + 2'd1;
        end
    end
`else
    assign retry_left = 1'b0;
`endif

    // Frame sequencer: all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            byte_q        <= 8'h00;
            parity_q      <= 1'b0;
            frame_q       <= 10'h000;
            bitcnt_q      <= 4'd0;
            inh_cnt_q     <= '0;
            wd_q          <= '0;
            ack_q         <= 1'b0;
            tx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_ok_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            ack_ok_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            if (attempt_end) begin
                if (attempt_ok || !retry_left) begin
                    state_q       <= IDLE;
                    tx_ready_q    <= 1'b1;
                    busy_q        <= 1'b0;
                    clk_oe_q      <= 1'b0;
                    data_oe_q     <= 1'b0;
                    done_q        <= 1'b1;
                    ack_ok_q      <= attempt_ok;
                    err_timeout_q <= timeout_ev;
                end else begin
                    // Another attempt with the same latched byte
                    state_q   <= INHIBIT;
                    clk_oe_q  <= 1'b1;
                    data_oe_q <= 1'b0;
                    inh_cnt_q <= INH_LOAD;
                end
            end else begin
                if (wd_active && wd_q != '0) begin
                    wd_q <= wd_q - WD_W'(1);
                end
                case (state_q)
                    IDLE: begin
                        if (tx_valid && tx_ready_q) begin
                            byte_q     <= tx_data;
                            parity_q   <= ~^tx_data;
                            bitcnt_q   <= 4'd0;
                            state_q    <= INHIBIT;
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            clk_oe_q   <= 1'b1;
                            inh_cnt_q  <= INH_LOAD;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt_q == '0) begin
                            state_q   <= REQ;
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b1;
                            wd_q      <= START_LOAD;
                            frame_q   <= {1'b1, parity_q, byte_q};
                            bitcnt_q  <= 4'd0;
                        end else begin
                            inh_cnt_q <= inh_cnt_q - INH_W'(1);
                            // Start bit goes low in the last inhibit cycle
                            if (inh_cnt_q == INH_W'(1)) begin
                                data_oe_q <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        if (clk_fall) begin
                            data_oe_q <= ~frame_q[0];
                            frame_q   <= {1'b0, frame_q[9:1]};
                            bitcnt_q  <= 4'd1;
                            wd_q      <= BIT_LOAD;
                            state_q   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (clk_fall) begin
                            data_oe_q <= ~frame_q[0];
                            frame_q   <= {1'b0, frame_q[9:1]};
                            bitcnt_q  <= bitcnt_q + 4'd1;
                            wd_q      <= BIT_LOAD;
                            if (bitcnt_q == 4'(PS2_FRAME_BITS - 1)) begin
                                state_q <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            ack_q   <= ~data_sync;
                            wd_q    <= BIT_LOAD;
                            state_q <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        // Exit handled by finish_ev above
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign err_timeout = err_timeout_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
